e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multiply/divide unit in the Execute stage. Feeds the EX/MEM register, which carries Eout into the Memory stage.
- Holds the architectural HI/LO registers and runs mult/multu/div/divu with a fixed multi-cycle latency.
- Executes mthi/mtlo.
- Drives busy, which the hazard unit combines with start to stall MD-class instructions in Decode.
- Suppresses any new operation while the Memory-stage exception/interrupt request (Req) is asserted.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  Execute-stage instruction is mult/multu/div/divu (valid with MDOp)
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Req  input  1  exception/interrupt request from the Memory-stage CP0 (flush in progress)
- busy  output  1  operation in flight
- HI  output  32  current HI register
- LO  output  32  current LO register

Behaviour:
- Reset: clk edge with reset=1 forces busy=0, HI=0, LO=0, cnt=0, temp regs=0. Reset aborts any in-flight operation; no HI/LO commit.
- Accept condition: start=1, MDOp in 1..4, busy=0, Req=0. All other combinations of start are ignored.
- On an accept edge:
  - Compute the result into tempHI/tempLO.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1 from the next cycle.
- While busy=1: cnt decrements each edge. On the edge where cnt==1, HI/LO ← tempHI/tempLO and busy → 0 in the same edge.
- Timing: busy is high for exactly N cycles after the accept cycle. New HI/LO are visible in the first cycle with busy=0.
- Back-to-back: a new accept is legal in the first cycle with busy=0.
- HI/LO are stable throughout busy; reads during busy see the old values. The hazard unit stalls mfhi/mflo while start|busy.
- mult: signed 32×32 → 64; HI=[63:32], LO=[31:0].
- multu: same as mult, unsigned operands.
- div: signed division.
  - LO=quotient, truncated toward zero.
  - HI=remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned division; LO=quotient, HI=remainder.
- Divide by zero (B==0, div or divu): the operation is accepted and busy runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- mthi/mtlo (MDOp 5/6):
  - Write HI or LO with A on the edge when busy=0 and Req=0.
  - Ignored when busy=1 or Req=1.
  - start is don't-care for these ops.
- Req does not cancel an in-flight operation; it only blocks new accepts and mthi/mtlo writes. The flushed instruction is never re-issued into the unit.
- Reset has priority over every other event on the same edge.
- busy, HI and LO are registered outputs; there is no combinational path from inputs to outputs.

Test Plan:
- Unsigned multiply: multu, A=0xFFFFFFFF, B=2, start one cycle → busy high cycles 1..5; cycle 6 shows HI=0x00000001, LO=0xFFFFFFFE, busy=0.
- Signed multiply and divide:
  - mult, A=0xFFFFFFFD (-3), B=7 → after 5 busy cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Then div, A=0xFFFFFFF9 (-7), B=2 → 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Edge divides:
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu 5/0 with HI=0x11, LO=0x22 preset via mthi/mtlo → busy 10 cycles, HI/LO remain 0x11/0x22.
- Req interaction:
  - start=1, MDOp=1, Req=1 → busy stays 0, HI/LO unchanged.
  - mtlo A=0x5A with Req=1 → LO unchanged.
  - Req asserted mid-div → operation completes and commits normally.
- Ignored requests while busy: during busy, assert start with a divu and mthi A=0x1234 → both ignored; the original result commits; the busy count is not extended.
- Reset mid-operation: reset in busy cycle 3 of a mult → next cycle busy=0, HI=LO=0; the pending result is never committed in later cycles.

Source files
------------

// File: rtl/e_mdu.sv
// ============================================================================
// Module : e_mdu
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_temp_hi;
  logic [31:0]        r_temp_lo;
  logic               r_commit;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_is_md;
  logic               w_accept;
  logic               w_b_zero;
  logic               w_sdiv_ovf;
  logic [31:0]        w_divisor;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;

  assign w_is_md  = (MDOp >= c_OP_MULT) && (MDOp <= c_OP_DIVU);
  assign w_accept = start && w_is_md && !r_busy && !Req;
  assign w_b_zero = (B == 32'd0);

  // Substituting a divisor of 1 covers both divide-by-zero (result discarded)
  // and the signed overflow case, whose architected result is A / 1 with rem 0.
  assign w_sdiv_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF) && (MDOp == c_OP_DIV);
  assign w_divisor  = (w_b_zero || w_sdiv_ovf) ? 32'd1 : B;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_quot_s = $signed(A) / $signed(w_divisor);
  assign w_rem_s  = $signed(A) % $signed(w_divisor);
  assign w_quot_u = A / w_divisor;
  assign w_rem_u  = A % w_divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_temp_hi <= 32'd0;
      r_temp_lo <= 32'd0;
      r_commit  <= 1'b0;
      r_cnt     <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (r_cnt == c_CNT_W'(1)) begin
        r_busy <= 1'b0;
        if (r_commit) begin
          r_hi <= r_temp_hi;
          r_lo <= r_temp_lo;
        end
      end
    end else if (w_accept) begin
      r_busy <= 1'b1;
      case (MDOp)
        c_OP_MULT: begin
          r_temp_hi <= w_prod_s[63:32];
          r_temp_lo <= w_prod_s[31:0];
          r_commit  <= 1'b1;
          r_cnt     <= c_CNT_W'(MULT_CYCLES);
        end
        c_OP_MULTU: begin
          r_temp_hi <= w_prod_u[63:32];
          r_temp_lo <= w_prod_u[31:0];
          r_commit  <= 1'b1;
          r_cnt     <= c_CNT_W'(MULT_CYCLES);
        end
        c_OP_DIV: begin
          r_temp_hi <= w_rem_s;
          r_temp_lo <= w_quot_s;
          r_commit  <= !w_b_zero;
          r_cnt     <= c_CNT_W'(DIV_CYCLES);
        end
        default: begin
          r_temp_hi <= w_rem_u;
          r_temp_lo <= w_quot_u;
          r_commit  <= !w_b_zero;
          r_cnt     <= c_CNT_W'(DIV_CYCLES);
        end
      endcase
    end else if (!Req) begin
      if (MDOp == c_OP_MTHI) r_hi <= A;
      if (MDOp == c_OP_MTLO) r_lo <= A;
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

`default_nettype wire
